io_pattern_checker: RTL and testbench

Parametrised checker that watches the `mprj_io` pad bus and confirms that firmware (e.g. an io_test image loaded from SPI flash) drives an expected sequence of patterns. It synchronises the pads, steps through a walking-one, binary-count or toggle sequence, and requires each pattern to be stable for a set number of cycles. A per-step timeout bounds each step, and the block reports a sticky pass/fail result with failure diagnostics. It sits beside the caravel instance in the io test environment and is synthesisable, so the same block can be reused on an FPGA bring-up board.

---
 rtl/io_pattern_checker.sv | 161 ++++++++++++++++
 tb/tb_io_pattern_checker.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_pattern_checker.sv
// Pad-bus sequence checker: synchronises io_in and confirms that firmware steps through
// walking-one, count or toggle patterns, each held for HOLD cycles within a per-step timeout.
module io_pattern_checker #(
  parameter int WIDTH       = 38,
  parameter int STEPS       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD        = 4,
  parameter int TMO_W       = 16,
  localparam int SW         = $clog2(((WIDTH > STEPS) ? WIDTH : STEPS) + 1)
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [WIDTH-1:0] io_in,
  input  logic [WIDTH-1:0] mask,
  input  logic [1:0]       mode,
  input  logic [TMO_W-1:0] timeout,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [SW-1:0]    step,
  output logic [WIDTH-1:0] err_bits
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [SW-1:0] LAST_WALK = SW'(WIDTH - 1);
  localparam logic [SW-1:0] LAST_SEQ  = SW'(STEPS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_PASS, ST_FAIL} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]   mask_q;
  logic [1:0]         mode_q;
  logic [TMO_W-1:0]   tmo_q, tmo_cnt_q;
  logic [HW-1:0]      hold_q;
  logic [SW-1:0]      step_q;
  logic [WIDTH-1:0]   err_q;
  logic               done_q, pass_q, fail_q;

  logic [WIDTH-1:0]   sync_io, exp_pat, diff;
  logic               match, advance, tmo_fire, last_step;

  function automatic logic [WIDTH-1:0] expected_pat(input logic [1:0] md, input logic [SW-1:0] k);
    case (md)
      2'd1:    return WIDTH'(k);
      2'd2:    return {WIDTH{k[0]}};
      default: return {{(WIDTH-1){1'b0}}, 1'b1} << k;
    endcase
  endfunction

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_CHECK;
        ST_CHECK: begin
          if (advance && last_step) state_d = ST_PASS;
          else if (tmo_fire)        state_d = ST_FAIL;
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Advance takes priority over a timeout landing on the same cycle.
  always_comb begin
    sync_io   = sync_q[SYNC_STAGES-1];
    exp_pat   = expected_pat(mode_q, step_q);
    diff      = (sync_io ^ exp_pat) & mask_q;
    match     = (diff == '0);
    last_step = (mode_q == 2'd1 || mode_q == 2'd2) ? (step_q == LAST_SEQ) : (step_q == LAST_WALK);
    advance   = (state_q == ST_CHECK) && match && (hold_q == HOLD_LAST);
    tmo_fire  = (state_q == ST_CHECK) && (tmo_q != '0) &&
                (tmo_cnt_q == tmo_q - TMO_W'(1)) && !advance;
    busy      = (state_q != ST_IDLE);
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      mask_q    <= '0;
      mode_q    <= '0;
      tmo_q     <= '0;
      tmo_cnt_q <= '0;
      hold_q    <= '0;
      step_q    <= '0;
      err_q     <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else if (abort) begin
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      hold_q    <= '0;
      tmo_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mask_q    <= mask;
            mode_q    <= mode;
            tmo_q     <= timeout;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            err_q     <= '0;
            step_q    <= '0;
            hold_q    <= '0;
            tmo_cnt_q <= '0;
          end
        end
        ST_CHECK: begin
          if (advance) begin
            hold_q    <= '0;
            tmo_cnt_q <= '0;
            if (!last_step) step_q <= step_q + SW'(1);
          end else begin
            hold_q    <= match ? hold_q + HW'(1) : '0;
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            if (tmo_fire) err_q <= diff;
          end
        end
        ST_PASS: begin
          done_q <= 1'b1;
          pass_q <= 1'b1;
        end
        default: begin
          done_q <= 1'b1;
          fail_q <= 1'b1;
        end
      endcase
    end
  end

  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign step     = step_q;
  assign err_bits = err_q;

endmodule

// File: tb/tb_io_pattern_checker.sv
// Directed bench for io_pattern_checker: walking-one, count-mode timeout, glitch rejection,
// masking, abort/start interplay and mid-run reset.
module tb_io_pattern_checker;

  localparam int W  = 38;
  localparam int ST = 16;
  localparam int TW = 16;
  localparam int SW = $clog2(((W > ST) ? W : ST) + 1);

  logic          clock = 1'b0;
  logic          resetb;
  logic [W-1:0]  io_in;
  logic [W-1:0]  mask;
  logic [1:0]    mode;
  logic [TW-1:0] timeout;
  logic          start;
  logic          abort;
  logic          busy, done, pass, fail;
  logic [SW-1:0] step;
  logic [W-1:0]  err_bits;

  int errors = 0;
  int checks = 0;

  io_pattern_checker #(
    .WIDTH(W), .STEPS(ST), .SYNC_STAGES(2), .HOLD(4), .TMO_W(TW)
  ) dut (
    .clock(clock), .resetb(resetb), .io_in(io_in), .mask(mask), .mode(mode),
    .timeout(timeout), .start(start), .abort(abort), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .step(step), .err_bits(err_bits)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic start_run(input logic [1:0] md, input logic [TW-1:0] tmo, input logic [W-1:0] msk);
    mode    = md;
    timeout = tmo;
    mask    = msk;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic test_reset;
    resetb = 1'b0; io_in = '0; mask = '0; mode = '0; timeout = '0; start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++;
    if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %0b expected 0", pass); end
    checks++;
    if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail: got %0b expected 0", fail); end
    checks++;
    if (step !== '0) begin errors++; $display("FAIL reset_step: got %0d expected 0", step); end
    checks++;
    if (err_bits !== '0) begin errors++; $display("FAIL reset_err_bits: got %h expected 0", err_bits); end
    checks++;
    resetb = 1'b1;
    tick();
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0b expected 0", busy); end
    checks++;
  endtask

  task automatic test_walking_one;
    int n = 0;
    int done_at = -1;
    io_in = W'(1);
    repeat (4) tick();
    start_run(2'd0, TW'(100), {W{1'b1}});
    if (busy !== 1'b1) begin errors++; $display("FAIL walk_busy_rise: got %0b expected 1", busy); end
    checks++;
    for (int k = 0; k < W; k++) begin
      io_in = {{(W-1){1'b0}}, 1'b1} << k;
      for (int j = 0; j < 10; j++) begin
        tick();
        n++;
        if (done === 1'b1 && done_at < 0) done_at = n;
      end
    end
    if (done_at !== 377) begin errors++; $display("FAIL walk_done_cycle: got %0d expected 377", done_at); end
    checks++;
    if (pass !== 1'b1) begin errors++; $display("FAIL walk_pass: got %0b expected 1", pass); end
    checks++;
    if (fail !== 1'b0) begin errors++; $display("FAIL walk_fail: got %0b expected 0", fail); end
    checks++;
    if (step !== SW'(37)) begin errors++; $display("FAIL walk_step: got %0d expected 37", step); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL walk_busy_end: got %0b expected 0", busy); end
    checks++;
  endtask

  task automatic test_timeout;
    int n = 0;
    int fail_at = -1;
    io_in = '0;
    repeat (4) tick();
    start_run(2'd1, TW'(50), {W{1'b1}});
    for (int k = 0; k < 5; k++) begin
      io_in = W'(k);
      repeat (10) begin
        tick();
        n++;
        if (fail === 1'b1 && fail_at < 0) fail_at = n;
      end
    end
    while (fail_at < 0 && n < 200) begin
      tick();
      n++;
      if (fail === 1'b1) fail_at = n;
    end
    if (fail_at !== 97) begin errors++; $display("FAIL tmo_fail_cycle: got %0d expected 97", fail_at); end
    checks++;
    if (step !== SW'(5)) begin errors++; $display("FAIL tmo_step: got %0d expected 5", step); end
    checks++;
    if (err_bits !== W'(1)) begin errors++; $display("FAIL tmo_err_bits: got %h expected 1", err_bits); end
    checks++;
    if (done !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_flags: got done=%0b pass=%0b busy=%0b expected 1 0 0", done, pass, busy);
    end
    checks++;
  endtask

  task automatic test_glitch;
    io_in = '0;
    repeat (4) tick();
    start_run(2'd1, TW'(0), {W{1'b1}});
    repeat (10) tick();
    io_in = W'(1);
    repeat (3) tick();
    io_in = '0;
    repeat (12) tick();
    if (step !== SW'(1)) begin errors++; $display("FAIL glitch_no_advance: got step %0d expected 1", step); end
    checks++;
    io_in = W'(1);
    repeat (4) tick();
    io_in = '0;
    repeat (6) tick();
    if (step !== SW'(2)) begin errors++; $display("FAIL glitch_hold_advance: got step %0d expected 2", step); end
    checks++;
    if (busy !== 1'b1 || fail !== 1'b0) begin
      errors++;
      $display("FAIL glitch_no_timeout: got busy=%0b fail=%0b expected 1 0", busy, fail);
    end
    checks++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_mask;
    int n = 0;
    int done_at = -1;
    logic [63:0] rnd;
    io_in = '0;
    repeat (4) tick();
    start_run(2'd2, TW'(0), W'(38'h0F));
    for (int k = 0; k < ST; k++) begin
      for (int j = 0; j < 10; j++) begin
        rnd   = {$urandom(), $urandom()};
        io_in = {rnd[W-1:4], ((k % 2) == 1) ? 4'hF : 4'h0};
        tick();
        n++;
        if (done === 1'b1 && done_at < 0) done_at = n;
      end
    end
    if (done_at !== 157) begin errors++; $display("FAIL mask_done_cycle: got %0d expected 157", done_at); end
    checks++;
    if (pass !== 1'b1 || fail !== 1'b0) begin
      errors++;
      $display("FAIL mask_result: got pass=%0b fail=%0b expected 1 0", pass, fail);
    end
    checks++;
    if (err_bits !== '0) begin errors++; $display("FAIL mask_err_bits: got %h expected 0", err_bits); end
    checks++;
    if (step !== SW'(15)) begin errors++; $display("FAIL mask_step: got %0d expected 15", step); end
    checks++;
  endtask

  task automatic test_abort_start;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    if (done !== 1'b0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle_clear: got done=%0b pass=%0b expected 0 0", done, pass);
    end
    checks++;
    if (step !== SW'(15)) begin errors++; $display("FAIL abort_idle_step: got %0d expected 15", step); end
    checks++;
    io_in = W'(1);
    repeat (4) tick();
    start_run(2'd0, TW'(0), {W{1'b1}});
    for (int k = 0; k < 7; k++) begin
      io_in = {{(W-1){1'b0}}, 1'b1} << k;
      repeat (10) tick();
    end
    if (step !== SW'(7) || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_reach_step7: got step=%0d busy=%0b expected 7 1", step, busy);
    end
    checks++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags: got busy=%0b done=%0b pass=%0b fail=%0b expected 0 0 0 0",
               busy, done, pass, fail);
    end
    checks++;
    if (step !== SW'(7)) begin errors++; $display("FAIL abort_step_kept: got %0d expected 7", step); end
    checks++;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    if (busy !== 1'b0 || step !== SW'(7)) begin
      errors++;
      $display("FAIL abort_beats_start: got busy=%0b step=%0d expected 0 7", busy, step);
    end
    checks++;
    io_in = W'(1);
    repeat (4) tick();
    start_run(2'd0, TW'(0), {W{1'b1}});
    if (busy !== 1'b1 || step !== '0) begin
      errors++;
      $display("FAIL restart: got busy=%0b step=%0d expected 1 0", busy, step);
    end
    checks++;
    repeat (6) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    if (busy !== 1'b1 || step !== SW'(1)) begin
      errors++;
      $display("FAIL start_in_check: got busy=%0b step=%0d expected 1 1", busy, step);
    end
    checks++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset_midrun;
    io_in = '0;
    repeat (4) tick();
    start_run(2'd1, TW'(0), {W{1'b1}});
    for (int k = 0; k < 10; k++) begin
      io_in = W'(k);
      repeat (10) tick();
    end
    if (step !== SW'(10) || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_step10: got step=%0d busy=%0b expected 10 1", step, busy);
    end
    checks++;
    #2 resetb = 1'b0;
    #1;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset_flags: got busy=%0b done=%0b pass=%0b fail=%0b expected 0 0 0 0",
               busy, done, pass, fail);
    end
    checks++;
    if (step !== '0 || err_bits !== '0) begin
      errors++;
      $display("FAIL midrun_reset_data: got step=%0d err_bits=%h expected 0 0", step, err_bits);
    end
    checks++;
    tick();
    resetb = 1'b1;
    io_in  = '0;
    repeat (3) tick();
    start_run(2'd1, TW'(0), {W{1'b1}});
    if (busy !== 1'b1 || step !== '0) begin
      errors++;
      $display("FAIL midrun_fresh_start: got busy=%0b step=%0d expected 1 0", busy, step);
    end
    checks++;
    repeat (4) tick();
    if (step !== SW'(1)) begin errors++; $display("FAIL midrun_first_advance: got %0d expected 1", step); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_walking_one();
    test_timeout();
    test_glitch();
    test_mask();
    test_abort_start();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
